ram0_arbiter: RTL and testbench
===============================

// Module: ram0_arbiter
// PURPOSE
//   Two-port arbiter and sequencer for the ram0 dual-port block RAM.
//   Port 0 (picorv32 native mem bus) and port 1 (host loader/DMA) share one RAM.
//   Each port uses a valid/ready/wstrb bus; the arbiter serialises accesses and drives the RAM write/read ports.
//   Byte-strobed partial writes are done as read-modify-write, because ram0 has no byte enables.
// PARAMETERS
//   DWIDTH  32  RAM/bus data width; must be a multiple of 8; NB = DWIDTH/8 strobe bits
//   AWIDTH  12  RAM word-address width (depth 1<<AWIDTH)
// PORTS
//   clk          in   1       single clock for arbiter and RAM
//   reset        in   1       asynchronous, active-high
//   pN_valid     in   1       request valid, N=0,1; held until pN_ready
//   pN_addr      in   AWIDTH  word address
//   pN_wdata     in   DWIDTH  write data
//   pN_wstrb     in   NB      byte strobes; all-zero = read
//   pN_ready     out  1       one-cycle completion pulse
//   pN_rdata     out  DWIDTH  read data, valid while pN_ready=1 for a read
//   ram_wren     out  1       to ram0 wren
//   ram_wraddr   out  AWIDTH  to ram0 wraddr
//   ram_di       out  DWIDTH  to ram0 di
//   ram_rden     out  1       to ram0 rden
//   ram_rdaddr   out  AWIDTH  to ram0 rdaddr
//   ram_do       in   DWIDTH  from ram0 do; 1-cycle registered read
// BEHAVIOUR
//   Reset: FSM=IDLE; last_grant=1, so port 0 wins first; all outputs 0; latched request cleared.
//   FSM: IDLE -> (grant; latch port id, addr, wdata, wstrb) -> one of:
//     full write (wstrb all ones) -> WR: ram_wren=1, ram_di=wdata; pN_ready=1 -> IDLE
//     read (wstrb=0)     -> RD: ram_rden=1 -> RESP: pN_rdata=ram_do, pN_ready=1 -> IDLE
//     partial write      -> RD: ram_rden=1 -> MERGE: ram_wren=1, ram_di[b]=wstrb[b]?wdata[b]:ram_do[b]; pN_ready=1 -> IDLE
//   Latency from the grant cycle: full write completes 1 cycle later; read and partial write complete 2 cycles later.
//   Only the granted port sees ready; the other port's ready and rdata stay 0.
//   RAM write and read addresses both carry the latched addr. ram_wren and ram_rden are never high together.
//   Arbitration: only in IDLE. Single valid wins. If both are valid, the port != last_grant wins (round-robin).
//     last_grant updates on each grant.
//   After a ready pulse the FSM is in IDLE. A requester that still holds valid in the cycle after ready
//     is a new request; this matches picorv32, which drops valid after ready.
//   pN_* inputs are sampled only at grant; changes while a request is in flight are ignored.
//   Back-to-back: minimum 1 IDLE cycle between accesses; each request completes in 2 or 3 cycles including the grant cycle.
//   Reset mid-operation: FSM goes to IDLE asynchronously; ram_wren and ram_rden drop at once.
//     No merge write is issued; the in-flight request is lost with no ready pulse.
// CONFIGURATION
//   RAM_ARB_FIXED_PRIO_EN defined: port 0 always wins simultaneous requests; last_grant is not used.
//   Not defined (default): round-robin as above; no port starves.
// STRUCTURE
//   Package ram_arb_pkg holds:
//     - state enum {IDLE, RD, RESP, WR, MERGE}
//     - localparam NB, function byte_merge(old, new, strb)
//   Sub-module ram_arb_rr: 2-way round-robin picker (inputs: req[1:0], last; output: gnt[1:0]).
//     It contains the RAM_ARB_FIXED_PRIO_EN ifdef.
//   ram0 is instantiated by the parent, not by this block.
// TESTING
//   - Reset with both valid=1: after release, port 0 is granted first; RAM outputs and ready stay 0 while reset=1.
//   - p0 full write addr 5 data 0xDEADBEEF wstrb 0xF, then p0 read addr 5:
//     write ready 1 cycle after grant; read ready 2 cycles after grant with rdata=0xDEADBEEF.
//   - Partial write, RAM[7]=0x11223344, wstrb 0b0101, wdata 0xAABBCCDD:
//     RD then MERGE writes 0x11BB33DD; ready on the MERGE cycle; a following read returns 0x11BB33DD.
//   - Both ports valid continuously for 8 requests:
//     grants alternate 0,1,0,1...; with RAM_ARB_FIXED_PRIO_EN only port 0 is served until it drops valid.
//   - Reset asserted during the RD cycle of a partial write:
//     no ram_wren pulse; RAM word unchanged; no ready; FSM IDLE after release.
//   - Change pN_addr and pN_wdata during RD: the access uses the values latched at grant; verify against a scoreboard.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the ram0 two-port arbiter.
package ram_arb_pkg;

  // Default geometry; the arbiter modules take their own DWIDTH/AWIDTH parameters.
  localparam int unsigned DefDwidth = 32;
  localparam int unsigned DefAwidth = 12;
  localparam int unsigned NB        = DefDwidth / 8;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StResp,
    StWr,
    StMerge
  } state_e;

  // One byte lane of a read-modify-write: keep the stored byte unless strobed.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       strb);
    return strb ? new_b : old_b;
  endfunction

endpackage

// File: rtl/ram0_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and ram0.
// slave: the arbiter's view; master: the requesters' and RAM's view.
interface ram0_arbiter_if #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 12
);
  localparam int unsigned NB = DWIDTH / 8;

  logic              p0_valid;
  logic [AWIDTH-1:0] p0_addr;
  logic [DWIDTH-1:0] p0_wdata;
  logic [NB-1:0]     p0_wstrb;
  logic              p0_ready;
  logic [DWIDTH-1:0] p0_rdata;

  logic              p1_valid;
  logic [AWIDTH-1:0] p1_addr;
  logic [DWIDTH-1:0] p1_wdata;
  logic [NB-1:0]     p1_wstrb;
  logic              p1_ready;
  logic [DWIDTH-1:0] p1_rdata;

  logic              ram_wren;
  logic [AWIDTH-1:0] ram_wraddr;
  logic [DWIDTH-1:0] ram_di;
  logic              ram_rden;
  logic [AWIDTH-1:0] ram_rdaddr;
  logic [DWIDTH-1:0] ram_do;

  modport slave (
    input  p0_valid, p0_addr, p0_wdata, p0_wstrb,
    output p0_ready, p0_rdata,
    input  p1_valid, p1_addr, p1_wdata, p1_wstrb,
    output p1_ready, p1_rdata,
    output ram_wren, ram_wraddr, ram_di, ram_rden, ram_rdaddr,
    input  ram_do
  );

  modport master (
    output p0_valid, p0_addr, p0_wdata, p0_wstrb,
    input  p0_ready, p0_rdata,
    output p1_valid, p1_addr, p1_wdata, p1_wstrb,
    input  p1_ready, p1_rdata,
    input  ram_wren, ram_wraddr, ram_di, ram_rden, ram_rdaddr,
    output ram_do
  );

endinterface

// File: rtl/ram_arb_rr.sv
// Two-way request picker.
// Build option RAM_ARB_FIXED_PRIO_EN: port 0 always wins a tie and `last` is ignored;
// otherwise a tie goes to the port that was not granted last.
module ram_arb_rr (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

`ifdef RAM_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;

  // Fixed priority: port 0 first.
  always_comb begin
    gnt = 2'b00;
    if (req[0])      gnt = 2'b01;
    else if (req[1]) gnt = 2'b10;
  end
`else
  // Round-robin: on a tie, the port other than `last` wins.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end
`endif

endmodule

// File: rtl/ram0_arbiter.sv
// Two-port arbiter/sequencer for the ram0 dual-port block RAM. Serialises port 0 and
// port 1 accesses; byte-strobed writes are done as read-modify-write since ram0 has no
// byte enables. Build option RAM_ARB_FIXED_PRIO_EN selects fixed priority (see ram_arb_rr).
module ram0_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  ram0_arbiter_if.slave    bus
);

  localparam int unsigned Nb = DWIDTH / 8;

  state_e            state_q, state_d;
  logic              port_q;
  logic              last_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic [Nb-1:0]     wstrb_q;

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              grant;
  logic              gnt_port;
  logic [AWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0] sel_wdata;
  logic [Nb-1:0]     sel_wstrb;

  logic              ram_wren;
  logic              ram_rden;
  logic [DWIDTH-1:0] ram_di;
  logic [DWIDTH-1:0] merged;
  logic              done;
  logic              resp;

  assign req = {bus.p1_valid, bus.p0_valid};

  ram_arb_rr u_rr (
    .req  (req),
    .last (last_q),
    .gnt  (gnt)
  );

  // Arbitration result is only acted on while idle.
  assign grant     = (state_q == StIdle) && (gnt != 2'b00);
  assign gnt_port  = gnt[1];
  assign sel_addr  = gnt_port ? bus.p1_addr  : bus.p0_addr;
  assign sel_wdata = gnt_port ? bus.p1_wdata : bus.p0_wdata;
  assign sel_wstrb = gnt_port ? bus.p1_wstrb : bus.p0_wstrb;

  // State register and request latch; request fields are captured only at grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      port_q  <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        port_q  <= gnt_port;
        last_q  <= gnt_port;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        wstrb_q <= sel_wstrb;
      end
    end
  end

  // Next-state: full writes go straight to WR; reads and partial writes read first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (grant) state_d = (&sel_wstrb) ? StWr : StRd;
      end
      StRd:    state_d = (wstrb_q == '0) ? StResp : StMerge;
      StResp:  state_d = StIdle;
      StWr:    state_d = StIdle;
      StMerge: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // RAM strobes, write data and completion, decoded from the current state.
  always_comb begin
    ram_wren = 1'b0;
    ram_rden = 1'b0;
    ram_di   = '0;
    done     = 1'b0;
    resp     = 1'b0;
    merged   = '0;
    for (int b = 0; b < Nb; b++) begin
      merged[8*b +: 8] = byte_merge(bus.ram_do[8*b +: 8], wdata_q[8*b +: 8], wstrb_q[b]);
    end
    case (state_q)
      StWr: begin
        ram_wren = 1'b1;
        ram_di   = wdata_q;
        done     = 1'b1;
      end
      StRd: begin
        ram_rden = 1'b1;
      end
      StResp: begin
        done = 1'b1;
        resp = 1'b1;
      end
      StMerge: begin
        ram_wren = 1'b1;
        ram_di   = merged;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.ram_wren   = ram_wren;
  assign bus.ram_rden   = ram_rden;
  assign bus.ram_di     = ram_di;
  assign bus.ram_wraddr = addr_q;
  assign bus.ram_rdaddr = addr_q;

  // Only the port that owns the in-flight request sees ready/rdata.
  assign bus.p0_ready = done & ~port_q;
  assign bus.p1_ready = done & port_q;
  assign bus.p0_rdata = (resp && !port_q) ? bus.ram_do : '0;
  assign bus.p1_rdata = (resp && port_q)  ? bus.ram_do : '0;

endmodule

// File: tb/tb_ram0_arbiter.sv
// Self-checking bench for ram0_arbiter with a behavioural ram0 model.
module tb_ram0_arbiter;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 12;
  localparam int unsigned NBT = DW / 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram0_arbiter_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  ram0_arbiter #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ram0 model: synchronous write, registered read.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] ram_do_q = '0;
  assign bus.ram_do = ram_do_q;
  always @(posedge clk) begin
    if (bus.ram_wren) mem[bus.ram_wraddr] <= bus.ram_di;
    if (bus.ram_rden) ram_do_q <= mem[bus.ram_rdaddr];
  end

  // Reference model state: memory contents and which port was granted last.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit            last_m;
  int            n_tests = 0;
  int            n_fail  = 0;
  int            wren_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Invariants that must hold on every cycle.
  always @(negedge clk) begin
    if (bus.ram_wren) wren_cnt++;
    check("ram_wren_rden_excl", 64'(bus.ram_wren & bus.ram_rden), 64'd0);
    check("ready_excl", 64'(bus.p0_ready & bus.p1_ready), 64'd0);
    check("rdata_zero_without_ready",
          64'((!bus.p0_ready && bus.p0_rdata != '0) || (!bus.p1_ready && bus.p1_rdata != '0)),
          64'd0);
  end

  // Transaction-level model: returns the old word, applies strobed bytes.
  task automatic model_access(input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [NBT-1:0] s, output logic [DW-1:0] old);
    old = ref_mem[a];
    for (int b = 0; b < NBT; b++) if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
  endtask

  function automatic int exp_lat(input logic [NBT-1:0] s);
    return (s == '1) ? 1 : 2;
  endfunction

  task automatic drive(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [NBT-1:0] s);
    if (p == 0) begin
      bus.p0_addr = a; bus.p0_wdata = d; bus.p0_wstrb = s; bus.p0_valid = 1'b1;
    end else begin
      bus.p1_addr = a; bus.p1_wdata = d; bus.p1_wstrb = s; bus.p1_valid = 1'b1;
    end
  endtask

  task automatic undrive(input int p);
    if (p == 0) bus.p0_valid = 1'b0;
    else        bus.p1_valid = 1'b0;
  endtask

  // Wait (bounded) for any ready pulse; lat counts cycles after the cycle of the call.
  // Port `scr` gets its request fields scrambled once its request is in flight.
  task automatic wait_ready(input int scr, output int port, output int lat,
                            output logic [DW-1:0] rd);
    port = -1;
    lat  = 0;
    rd   = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.p0_ready || bus.p1_ready) begin
        port = bus.p1_ready ? 1 : 0;
        rd   = bus.p1_ready ? bus.p1_rdata : bus.p0_rdata;
        return;
      end
      if (i >= 1 && scr == 0) begin
        bus.p0_addr = AW'($urandom); bus.p0_wdata = $urandom; bus.p0_wstrb = NBT'($urandom);
      end else if (i >= 1 && scr == 1) begin
        bus.p1_addr = AW'($urandom); bus.p1_wdata = $urandom; bus.p1_wstrb = NBT'($urandom);
      end
      lat++;
    end
    $display("FAIL ready_timeout: got no ready, expected one within 10 cycles");
    n_tests++;
    n_fail++;
  endtask

  // One isolated request on one port, checked against the model.
  task automatic single(input string tag, input int p, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [NBT-1:0] s,
                        output logic [DW-1:0] rd);
    int gp, lat;
    logic [DW-1:0] old;
    @(posedge clk); #1;
    drive(p, a, d, s);
    wait_ready(-1, gp, lat, rd);
    check({tag, "_port"}, 64'(gp), 64'(p));
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat(s)));
    model_access(a, d, s, old);
    if (s == '0) check({tag, "_rdata_model"}, 64'(rd), 64'(old));
    last_m = p[0];
    @(posedge clk); #1;
    undrive(p);
  endtask

  typedef struct {
    int             port;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    logic [NBT-1:0] wstrb;
    logic [DW-1:0]  exp_rdata;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int            gp, lat, first, second, mask, exp_first;
    logic [DW-1:0] rd, old;
    logic [AW-1:0] op_a [2];
    logic [DW-1:0] op_d [2];
    logic [NBT-1:0] op_s [2];
    int            wren_snap;

    vecs[0] = '{0, 12'd5, 32'hDEADBEEF, 4'hF, 32'h0};
    vecs[1] = '{0, 12'd5, 32'h0,        4'h0, 32'hDEADBEEF};
    vecs[2] = '{1, 12'd7, 32'h11223344, 4'hF, 32'h0};
    vecs[3] = '{1, 12'd7, 32'hAABBCCDD, 4'h5, 32'h0};
    vecs[4] = '{0, 12'd7, 32'h0,        4'h0, 32'h11BB33DD};
    vecs[5] = '{1, 12'd5, 32'h0,        4'h0, 32'hDEADBEEF};
    vecs[6] = '{0, 12'd5, 32'h01020304, 4'hA, 32'h0};
    vecs[7] = '{1, 12'd5, 32'h0,        4'h0, 32'h01AD03EF};

    // Reset held with both ports requesting: nothing may move.
    reset = 1'b1;
    bus.p0_valid = 1'b0; bus.p1_valid = 1'b0;
    bus.p0_addr = '0; bus.p0_wdata = '0; bus.p0_wstrb = '0;
    bus.p1_addr = '0; bus.p1_wdata = '0; bus.p1_wstrb = '0;
    drive(0, 12'd1, 32'h00000001, 4'hF);
    drive(1, 12'd2, 32'h00000002, 4'hF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outputs_zero",
            64'({bus.ram_wren, bus.ram_rden, bus.p0_ready, bus.p1_ready, bus.ram_di != '0}),
            64'd0);
    end
    reset = 1'b0;
    last_m = 1'b1;
    wait_ready(-1, gp, lat, rd);
    check("reset_first_grant_port", 64'(gp), 64'd0);
    model_access(12'd1, 32'h00000001, 4'hF, old);
    @(posedge clk); #1;
    undrive(0);
    wait_ready(-1, gp, lat, rd);
    check("reset_second_grant_port", 64'(gp), 64'd1);
    check("reset_second_lat", 64'(lat), 64'd1);
    model_access(12'd2, 32'h00000002, 4'hF, old);
    last_m = 1'b1;
    @(posedge clk); #1;
    undrive(1);

    // Directed table: full write, read, partial write (RMW) and read-back.
    foreach (vecs[i]) begin
      single($sformatf("vec%0d", i), vecs[i].port, vecs[i].addr, vecs[i].wdata,
             vecs[i].wstrb, rd);
      if (vecs[i].wstrb == '0) check($sformatf("vec%0d_rdata", i), 64'(rd),
                                     64'(vecs[i].exp_rdata));
    end

    // Fill a small window so random reads see defined data.
    for (int a = 0; a < 16; a++) single("fill", a % 2, AW'(a), $urandom, 4'hF, rd);

    // Both ports held valid for 8 completions.
    drive(0, 12'd5, 32'h0, 4'h0);
    drive(1, 12'd7, 32'h0, 4'h0);
    for (int i = 0; i < 8; i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      exp_first = 0;
`else
      exp_first = last_m ? 0 : 1;
`endif
      wait_ready(-1, gp, lat, rd);
      check("contend_port", 64'(gp), 64'(exp_first));
      check("contend_rdata", 64'(rd), 64'(ref_mem[exp_first == 0 ? 12'd5 : 12'd7]));
      last_m = exp_first[0];
    end
    @(posedge clk); #1;
    undrive(0);
    undrive(1);

    // Reset in the RD cycle of a partial write: no merge, no ready, word untouched.
    single("pre_rst", 0, 12'd9, 32'hCAFEF00D, 4'hF, rd);
    @(posedge clk); #1;
    drive(0, 12'd9, 32'hFFFFFFFF, 4'h3);
    @(posedge clk); #1;
    check("midrst_in_rd", 64'(bus.ram_rden), 64'd1);
    wren_snap = wren_cnt;
    #1 reset = 1'b1;
    #1;
    check("midrst_strobes_drop", 64'({bus.ram_wren, bus.ram_rden}), 64'd0);
    undrive(0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_ready", 64'({bus.p0_ready, bus.p1_ready}), 64'd0);
    end
    reset = 1'b0;
    last_m = 1'b1;
    check("midrst_no_wren", 64'(wren_cnt), 64'(wren_snap));
    single("midrst_readback", 0, 12'd9, 32'h0, 4'h0, rd);
    check("midrst_word_unchanged", 64'(rd), 64'h00000000CAFEF00D);

    // Random rounds; in-flight request fields are scrambled after grant.
    for (int r = 0; r < 60; r++) begin
      mask = $urandom_range(1, 3);
      for (int p = 0; p < 2; p++) begin
        op_a[p] = AW'($urandom_range(0, 15));
        op_d[p] = $urandom;
        case ($urandom_range(0, 2))
          0:       op_s[p] = '0;
          1:       op_s[p] = '1;
          default: op_s[p] = NBT'($urandom_range(1, 14));
        endcase
      end
      @(posedge clk); #1;
      if (mask[0]) drive(0, op_a[0], op_d[0], op_s[0]);
      if (mask[1]) drive(1, op_a[1], op_d[1], op_s[1]);
`ifdef RAM_ARB_FIXED_PRIO_EN
      first = (mask == 3) ? 0 : (mask == 2 ? 1 : 0);
`else
      first = (mask == 3) ? (last_m ? 0 : 1) : (mask == 2 ? 1 : 0);
`endif
      second = 1 - first;
      wait_ready(first, gp, lat, rd);
      check("rand_first_port", 64'(gp), 64'(first));
      check("rand_first_lat", 64'(lat), 64'(exp_lat(op_s[first])));
      model_access(op_a[first], op_d[first], op_s[first], old);
      if (op_s[first] == '0) check("rand_first_rdata", 64'(rd), 64'(old));
      last_m = first[0];
      @(posedge clk); #1;
      undrive(first);
      if (mask == 3) begin
        wait_ready(second, gp, lat, rd);
        check("rand_second_port", 64'(gp), 64'(second));
        check("rand_second_lat", 64'(lat), 64'(exp_lat(op_s[second])));
        model_access(op_a[second], op_d[second], op_s[second], old);
        if (op_s[second] == '0) check("rand_second_rdata", 64'(rd), 64'(old));
        last_m = second[0];
        @(posedge clk); #1;
        undrive(second);
      end
    end

    // Final sweep of the random window through port 1.
    for (int a = 0; a < 16; a++) single("sweep", 1, AW'(a), 32'h0, 4'h0, rd);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish before 500000 ns");
    $fatal(1, "timeout");
  end

endmodule
